// File: rtl/mux_82_rr_sched.sv
// mux_82_rr_sched: round-robin select driver for the 4:1 mux_82.
// Picks a requesting channel, steers the mux to it, captures the settled
// mux output into a one-word output slot and acknowledges the channel.
// A per-channel burst limit stops one channel from monopolising the mux
// while other channels are waiting.
module mux_82_rr_sched #(
  parameter int WIDTH = 8,
  parameter int BURST = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] mux_out,
  input  logic             out_ready,
  output logic [1:0]       sel,
  output logic [3:0]       ack,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid
);

  typedef enum logic {
    IDLE = 1'b0,
    SEL  = 1'b1
  } state_t;

  localparam logic [3:0] BURST_LIM = 4'(BURST);

  state_t           state_reg, state_next;
  logic [1:0]       sel_reg, sel_next;
  logic [3:0]       ack_reg, ack_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic             out_valid_reg, out_valid_next;
  logic [1:0]       ptr_reg, ptr_next;
  logic [3:0]       burst_cnt_reg, burst_cnt_next;

  // Rotating scan order: offset gi looks at channel ptr+gi+1 (mod 4), so the
  // last entry is ptr itself and the first hit is the next channel in turn.
  logic [1:0] scan_idx [4];
  logic [3:0] scan_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_scan
      assign scan_idx[gi] = ptr_reg + 2'(gi + 1);
      assign scan_hit[gi] = req[scan_idx[gi]];
    end
  endgenerate

  logic       ptr_sole;
  logic       ptr_keeps;
  logic [1:0] winner;
  logic       slot_free;

  assign ptr_sole  = (req == (4'b0001 << ptr_reg));
  assign ptr_keeps = req[ptr_reg] && ((burst_cnt_reg < BURST_LIM) || ptr_sole);
  assign slot_free = !out_valid_reg || out_ready;

  // Winner selection: the last served channel keeps the mux until its burst
  // runs out (or nobody else wants it); otherwise the first requester in turn.
  always_comb begin
    winner = ptr_reg;
    if (!ptr_keeps) begin
      for (int k = 3; k >= 0; k--) begin
        if (scan_hit[k]) begin
          winner = scan_idx[k];
        end
      end
    end
  end

  // Next-state and output-slot logic; every register holds unless changed.
  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    ack_next       = 4'b0000;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    ptr_next       = ptr_reg;
    burst_cnt_next = burst_cnt_reg;

    // Consumer draining the slot; a capture below overrides this.
    if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (req != 4'b0000) begin
          sel_next   = winner;
          state_next = SEL;
        end
      end
      SEL: begin
        if (!req[sel_reg]) begin
          // Channel withdrew before being served: forget it, no bookkeeping.
          state_next = IDLE;
        end else if (slot_free) begin
          out_data_next  = mux_out;
          out_valid_next = 1'b1;
          ack_next       = 4'b0001 << sel_reg;
          if (sel_reg == ptr_reg) begin
            burst_cnt_next = (burst_cnt_reg == 4'hf) ? burst_cnt_reg
                                                     : burst_cnt_reg + 4'd1;
          end else begin
            ptr_next       = sel_reg;
            burst_cnt_next = 4'd1;
          end
          state_next = IDLE;
        end
        // Otherwise the slot is full and blocked: hold sel and wait.
      end
    endcase
  end

  // State registers with asynchronous reset; ptr starts at 3 so that
  // channel 0 is first in the rotating scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      sel_reg       <= 2'b00;
      ack_reg       <= 4'b0000;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= 2'b11;
      burst_cnt_reg <= 4'd0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      ack_reg       <= ack_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      ptr_reg       <= ptr_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  assign sel       = sel_reg;
  assign ack       = ack_reg;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_82_rr_sched.sv
// tb_mux_82_rr_sched: directed bench for the round-robin mux scheduler.
// A behavioural model tracks what the outputs must be and is compared on
// every clock; literal checks at key points pin the model itself.
module tb_mux_82_rr_sched;

  localparam int WIDTH = 8;
  localparam int BURST = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       req = 4'b0000;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] mux_out;
  logic [1:0]       sel;
  logic [3:0]       ack;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;

  logic [7:0] dvec [4] = '{8'h01, 8'h02, 8'h03, 8'h04};

  int checks = 0;
  int errors = 0;

  // The 4:1 mux itself, fed back into the scheduler.
  assign mux_out = dvec[sel];

  mux_82_rr_sched #(.WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .mux_out(mux_out),
    .out_ready(out_ready),
    .sel(sel),
    .ack(ack),
    .out_data(out_data),
    .out_valid(out_valid)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: a channel either is waiting to be chosen or has been
  // chosen and is waiting for room in the slot.
  logic [1:0] m_sel;
  logic [3:0] m_ack;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_chosen;
  logic [1:0] m_last;
  int         m_run;

  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] last, input int run);
    int c;
    if (r[last] && (run < BURST || r == (4'b0001 << last))) return last;
    for (int k = 1; k <= 4; k++) begin
      c = (int'(last) + k) % 4;
      if (r[c]) return 2'(c);
    end
    return last;
  endfunction

  // Model update on every clock, reset asynchronously like the design.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sel <= 2'd0; m_ack <= 4'd0; m_data <= 8'd0; m_valid <= 1'b0;
      m_chosen <= 1'b0; m_last <= 2'd3; m_run <= 0;
    end else begin
      m_ack <= 4'd0;
      if (m_valid && out_ready) m_valid <= 1'b0;
      if (!m_chosen) begin
        if (req != 4'd0) begin
          m_sel <= pick(req, m_last, m_run);
          m_chosen <= 1'b1;
        end
      end else if (!req[m_sel]) begin
        m_chosen <= 1'b0;
      end else if (!m_valid || out_ready) begin
        m_data <= dvec[m_sel];
        m_valid <= 1'b1;
        m_ack <= 4'b0001 << m_sel;
        if (m_sel == m_last) m_run <= (m_run < 15) ? m_run + 1 : 15;
        else begin
          m_last <= m_sel;
          m_run <= 1;
        end
        m_chosen <= 1'b0;
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("cyc_sel", 32'(sel), 32'(m_sel));
      chk("cyc_ack", 32'(ack), 32'(m_ack));
      chk("cyc_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) chk("cyc_data", 32'(out_data), 32'(m_data));
    end
  end

  task automatic wait_ack(output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (ack == 4'd0 && gap < 20);
    if (ack == 4'd0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout actual=none required=ack within 20 cycles");
    end
  endtask

  int exp_bsel [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int exp_bdat [9] = '{1, 1, 2, 2, 3, 3, 4, 4, 1};
  int gap;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    rst_n = 1'b1;

    // First word from channel 0
    req = 4'b0001;
    @(negedge clk);
    chk("t1_sel", 32'(sel), 32'h0);
    @(negedge clk);
    chk("t1_data", 32'(out_data), 32'h01);
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_ack", 32'(ack), 32'b0001);

    // Backpressure on channel 1
    req = 4'b0010;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_sel", 32'(sel), 32'h1);
    repeat (3) begin
      @(negedge clk);
      chk("bp_sel_hold", 32'(sel), 32'h1);
      chk("bp_ack", 32'(ack), 32'h0);
      chk("bp_data", 32'(out_data), 32'h01);
      chk("bp_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_cap_data", 32'(out_data), 32'h02);
    chk("bp_cap_ack", 32'(ack), 32'b0010);
    chk("bp_cap_valid", 32'(out_valid), 32'h1);

    // Abandon on channel 2, slot kept full
    req = 4'b0100;
    out_ready = 1'b0;
    @(negedge clk);
    chk("ab_sel", 32'(sel), 32'h2);
    req = 4'b0000;
    @(negedge clk);
    chk("ab_ack", 32'(ack), 32'h0);
    chk("ab_valid", 32'(out_valid), 32'h1);
    chk("ab_data", 32'(out_data), 32'h02);

    // Channel 3 served twice, exhausting its burst
    req = 4'b1000;
    out_ready = 1'b1;
    @(negedge clk);
    chk("c3_sel", 32'(sel), 32'h3);
    @(negedge clk);
    chk("c3_data", 32'(out_data), 32'h04);
    chk("c3_ack", 32'(ack), 32'b1000);
    wait_ack(gap);
    chk("c3b_ack", 32'(ack), 32'b1000);
    chk("c3b_gap", 32'(gap), 32'd2);

    // All channels requesting: two grants each in rotation
    req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      wait_ack(gap);
      chk("burst_sel", 32'(sel), 32'(exp_bsel[i]));
      chk("burst_data", 32'(out_data), 32'(exp_bdat[i]));
      chk("burst_gap", 32'(gap), 32'd2);
    end

    // Sole requester keeps the mux past its burst limit
    req = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      wait_ack(gap);
      chk("sole_ack", 32'(ack), 32'b0001);
      chk("sole_gap", 32'(gap), 32'd2);
    end

    // Asynchronous reset while a channel is selected and the slot is full
    req = 4'b0010;
    out_ready = 1'b0;
    @(negedge clk);
    chk("ar_pre_sel", 32'(sel), 32'h1);
    chk("ar_pre_valid", 32'(out_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_sel", 32'(sel), 32'h0);
    chk("ar_ack", 32'(ack), 32'h0);
    chk("ar_data", 32'(out_data), 32'h0);
    chk("ar_valid", 32'(out_valid), 32'h0);
    req = 4'b1000;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_c3_sel", 32'(sel), 32'h3);
    @(negedge clk);
    chk("ar_c3_data", 32'(out_data), 32'h04);
    chk("ar_c3_ack", 32'(ack), 32'b1000);
    req = 4'b0000;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
